// File: rtl/alu_sel_pkg.sv
// Shared types and constants for the ALU result selector.
package alu_sel_pkg;

    // Occupancy of the main/skid register pair
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    // Opcode map of the per-operation units feeding op_bus
    localparam int unsigned OP_ADD    = 0;
    localparam int unsigned OP_SUB    = 1;
    localparam int unsigned OP_X2     = 2;
    localparam int unsigned OP_DIV2   = 3;
    localparam int unsigned OP_AND    = 4;
    localparam int unsigned OP_OR     = 5;
    localparam int unsigned OP_XOR    = 6;
    localparam int unsigned OP_NOT    = 7;
    localparam int unsigned OP_EQ     = 8;
    localparam int unsigned OP_GT     = 9;
    localparam int unsigned OP_LT     = 10;
    localparam int unsigned OP_MAX    = 11;
    localparam int unsigned OP_KNIGHT = 12;

    // Default-configuration widths of one buffered entry
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_SEL_W = 4;

    // Buffered entry at default widths; parametrised modules mirror this layout locally
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_SEL_W-1:0] sel;
        logic                 illegal;
`ifdef ALU_SEL_STATUS_EN
        logic                 zero;
        logic                 sign;
`endif
    } alu_sel_entry_t;

endpackage

// File: rtl/alu_sel_pick.sv
// Combinational opcode decode: selects one result from op_bus, flags illegal opcodes.
// Status flags (zero/sign) only when ALU_SEL_STATUS_EN is defined.
module alu_sel_pick
    import alu_sel_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned NUM_OPS = 13,
    localparam int unsigned SEL_W   = $clog2(NUM_OPS)
) (
    input  logic [NUM_OPS*WIDTH-1:0] op_bus_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     illegal_o
`ifdef ALU_SEL_STATUS_EN
    ,
    output logic                     zero_o,
    output logic                     sign_o
`endif
);

    // Illegal opcodes return zero data so the entry is always fully defined
    always_comb begin
        data_o    = '0;
        illegal_o = (32'(sel_i) >= NUM_OPS);
        for (int unsigned k = 0; k < NUM_OPS; k++) begin
            if (sel_i == SEL_W'(k)) begin
                data_o = op_bus_i[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ALU_SEL_STATUS_EN
    assign zero_o = (data_o == '0);
    assign sign_o = data_o[WIDTH-1];
`endif

endmodule

// File: rtl/alu_result_sel.sv
// Registered ALU result selector with valid/ready handshake and 2-entry skid buffer.
// Optional status outputs (out_zero/out_sign) when ALU_SEL_STATUS_EN is defined.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter  int unsigned WIDTH   = 8,
    parameter  int unsigned NUM_OPS = 13,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned SEL_W   = $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_OPS*WIDTH-1:0] op_bus,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_illegal,
    output logic [CNT_W-1:0]         illegal_cnt
`ifdef ALU_SEL_STATUS_EN
    ,
    output logic                     out_zero,
    output logic                     out_sign
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             illegal;
`ifdef ALU_SEL_STATUS_EN
        logic             zero;
        logic             sign;
`endif
    } entry_t;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q;
    logic             out_valid_q;

    entry_t           entry;
    logic             in_fire;
    logic             out_fire;

    logic [WIDTH-1:0] pick_data;
    logic             pick_illegal;
`ifdef ALU_SEL_STATUS_EN
    logic             pick_zero;
    logic             pick_sign;
`endif

    alu_sel_pick #(
        .WIDTH   (WIDTH),
        .NUM_OPS (NUM_OPS)
    ) u_pick (
        .op_bus_i  (op_bus),
        .sel_i     (sel),
        .data_o    (pick_data),
        .illegal_o (pick_illegal)
`ifdef ALU_SEL_STATUS_EN
        ,
        .zero_o    (pick_zero),
        .sign_o    (pick_sign)
`endif
    );

    // Assemble the entry captured on an accepted input
    always_comb begin
        entry         = '0;
        entry.data    = pick_data;
        entry.sel     = sel;
        entry.illegal = pick_illegal;
`ifdef ALU_SEL_STATUS_EN
        entry.zero    = pick_zero;
        entry.sign    = pick_sign;
`endif
    end

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next-state: buffer occupancy, main/skid loading and saturating illegal counter
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = entry;
                end else if (in_fire) begin
                    skid_d  = entry;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        if (in_fire && entry.illegal && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and storage registers; handshake flags registered from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = main_q.data;
    assign out_sel     = main_q.sel;
    assign out_illegal = main_q.illegal;
    assign illegal_cnt = cnt_q;
`ifdef ALU_SEL_STATUS_EN
    assign out_zero    = main_q.zero;
    assign out_sign    = main_q.sign;
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Directed and randomized checks for alu_result_sel (status outputs when ALU_SEL_STATUS_EN).
module tb_alu_result_sel;
    import alu_sel_pkg::*;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned NUM_OPS = 13;
    localparam int unsigned SEL_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         sel;
    logic [NUM_OPS*WIDTH-1:0] op_bus;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_data;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_illegal;
    logic [7:0]               illegal_cnt;

    logic                     s_in_ready;
    logic                     s_out_valid;
    logic [WIDTH-1:0]         s_out_data;
    logic [SEL_W-1:0]         s_out_sel;
    logic                     s_out_illegal;
    logic [1:0]               s_illegal_cnt;
`ifdef ALU_SEL_STATUS_EN
    logic                     out_zero, out_sign, s_out_zero, s_out_sign;
`endif

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_result_sel #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
        .op_bus(op_bus), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
`ifdef ALU_SEL_STATUS_EN
        , .out_zero(out_zero), .out_sign(out_sign)
`endif
    );

    alu_result_sel #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .sel(sel),
        .op_bus(op_bus), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_sel(s_out_sel), .out_illegal(s_out_illegal), .illegal_cnt(s_illegal_cnt)
`ifdef ALU_SEL_STATUS_EN
        , .out_zero(s_out_zero), .out_sign(s_out_sign)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_ops();
        for (int k = 0; k < int'(NUM_OPS); k++) op_bus[k*WIDTH +: WIDTH] = 8'(8'h10 + k);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0;
        load_default_ops();
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else passed++;
        total++; if (illegal_cnt !== 8'd0) $display("FAIL reset_cnt got %0d exp 0", illegal_cnt); else passed++;
        total++; if ({out_data, out_sel, out_illegal} !== 13'd0)
            $display("FAIL reset_out_regs got %h/%h/%b exp 0/0/0", out_data, out_sel, out_illegal); else passed++;
    endtask

    task automatic test_all_ops();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < int'(NUM_OPS); k++) begin
            sel = SEL_W'(k);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + k) || out_sel !== SEL_W'(k) ||
                out_illegal !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL all_ops[%0d] got v=%b d=%h s=%0d il=%b rdy=%b exp v=1 d=%h s=%0d il=0 rdy=1",
                         k, out_valid, out_data, out_sel, out_illegal, in_ready, 8'(8'h10 + k), k);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL all_ops_drain got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; sel = 4'd0;
        tick();
        total++; if (in_ready !== 1'b1 || out_data !== 8'h10)
            $display("FAIL bp_first got rdy=%b d=%h exp rdy=1 d=10", in_ready, out_data); else passed++;
        sel = 4'd1;
        tick();
        total++; if (in_ready !== 1'b0 || out_data !== 8'h10)
            $display("FAIL bp_full got rdy=%b d=%h exp rdy=0 d=10", in_ready, out_data); else passed++;
        sel = 4'd2;
        tick(); tick();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h10 || out_sel !== 4'd0)
            $display("FAIL bp_hold got rdy=%b v=%b d=%h s=%0d exp rdy=0 v=1 d=10 s=0",
                     in_ready, out_valid, out_data, out_sel); else passed++;
        out_ready = 1'b1;
        tick();
        total++; if (out_data !== 8'h11 || out_sel !== 4'd1 || in_ready !== 1'b1)
            $display("FAIL bp_release1 got d=%h s=%0d rdy=%b exp d=11 s=1 rdy=1", out_data, out_sel, in_ready); else passed++;
        tick();
        total++; if (out_data !== 8'h12 || out_sel !== 4'd2 || out_valid !== 1'b1)
            $display("FAIL bp_release2 got d=%h s=%0d v=%b exp d=12 s=2 v=1", out_data, out_sel, out_valid); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = SEL_W'(13 + i);
            tick();
            total++;
            if (out_data !== 8'h00 || out_illegal !== 1'b1 || out_sel !== SEL_W'(13 + i) || illegal_cnt !== 8'(i + 1))
                $display("FAIL illegal[%0d] got d=%h il=%b s=%0d cnt=%0d exp d=00 il=1 s=%0d cnt=%0d",
                         i, out_data, out_illegal, out_sel, illegal_cnt, 13 + i, i + 1);
            else passed++;
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; in_valid = 1'b1; sel = 4'd13;
        tick(); tick();
        in_valid = 1'b0;
        tick();
        total++; if (s_illegal_cnt !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", s_illegal_cnt); else passed++;
        total++; if (illegal_cnt !== 8'd5) $display("FAIL wide_cnt got %0d exp 5", illegal_cnt); else passed++;
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0; in_valid = 1'b1; sel = 4'd4;
        tick();
        out_ready = 1'b1; sel = 4'd5;
        tick();
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== 8'h15)
            $display("FAIL simul got v=%b rdy=%b d=%h exp v=1 rdy=1 d=15", out_valid, in_ready, out_data); else passed++;
        in_valid = 1'b0;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL simul_drain got %b exp 0", out_valid); else passed++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic [WIDTH-1:0] exp_d;
        logic in_f, out_f;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sel       = SEL_W'($urandom_range(0, 15));
            for (int k = 0; k < int'(NUM_OPS); k++) op_bus[k*WIDTH +: WIDTH] = 8'($urandom);
            #1;
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                total++;
                if (q.size() == 0) $display("FAIL rand_extra got d=%h exp no output", out_data);
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) $display("FAIL rand_data got %h exp %h", out_data, exp_d);
                    else passed++;
                end
            end
            if (in_f) q.push_back((32'(sel) < NUM_OPS) ? op_bus[32'(sel)*WIDTH +: WIDTH] : 8'h00);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (out_valid) begin
                total++;
                if (q.size() == 0) $display("FAIL rand_drain_extra got d=%h exp no output", out_data);
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) $display("FAIL rand_drain got %h exp %h", out_data, exp_d);
                    else passed++;
                end
            end
            tick();
        end
        total++; if (q.size() != 0) $display("FAIL rand_lost got %0d left exp 0", q.size()); else passed++;
        load_default_ops();
    endtask

`ifdef ALU_SEL_STATUS_EN
    task automatic test_status();
        out_ready = 1'b1; in_valid = 1'b1; sel = SEL_W'(OP_SUB);
        op_bus[OP_SUB*WIDTH +: WIDTH] = 8'h00;
        tick();
        total++; if (out_zero !== 1'b1 || out_sign !== 1'b0)
            $display("FAIL status_zero got z=%b s=%b exp z=1 s=0", out_zero, out_sign); else passed++;
        op_bus[OP_SUB*WIDTH +: WIDTH] = 8'h80;
        tick();
        total++; if (out_zero !== 1'b0 || out_sign !== 1'b1)
            $display("FAIL status_sign got z=%b s=%b exp z=0 s=1", out_zero, out_sign); else passed++;
        sel = 4'd14;
        tick();
        total++; if (out_zero !== 1'b1 || out_sign !== 1'b0)
            $display("FAIL status_illegal got z=%b s=%b exp z=1 s=0", out_zero, out_sign); else passed++;
        in_valid = 1'b0;
        tick();
        load_default_ops();
    endtask
`endif

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; sel = 4'd3;
        tick();
        sel = 4'd14;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || out_data !== 8'h00 || out_illegal !== 1'b0)
            $display("FAIL midrst got v=%b cnt=%0d d=%h il=%b exp v=0 cnt=0 d=00 il=0",
                     out_valid, illegal_cnt, out_data, out_illegal); else passed++;
        tick();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL midrst_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_all_ops();
        test_backpressure();
        test_illegal();
        test_saturation();
        test_simultaneous();
        test_random();
`ifdef ALU_SEL_STATUS_EN
        test_status();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
